// File: rtl/cam_fx_pkg.sv
// Shared types, palette constants and helpers for the camera particle overlay.
package cam_fx_pkg;

  localparam int unsigned CW_MAX   = 8;
  localparam int unsigned COORD_W  = 10;
  localparam int unsigned LFSR_W   = 16;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    MAPLE  = 2'd0,
    SNOW   = 2'd1,
    RAIN   = 2'd2,
    BYPASS = 2'd3
  } fx_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_UPDATE = 2'd1,
    ST_SPAWN  = 2'd2
  } upd_state_e;

  // Drift is kept as a 2-bit two's-complement step: +1, 0 or -1.
  localparam logic [1:0] DR_ZERO = 2'b00;
  localparam logic [1:0] DR_POS  = 2'b01;
  localparam logic [1:0] DR_NEG  = 2'b11;

  typedef struct packed {
    logic               active;
    logic [COORD_W-1:0] px;
    logic [COORD_W-1:0] py;
    logic [1:0]         vy;
    logic [1:0]         dr;
    logic [1:0]         pal;
  } particle_t;

  localparam logic [11:0] C_YEL  = 12'hFE0;
  localparam logic [11:0] C_ORG  = 12'hFA0;
  localparam logic [11:0] C_RED  = 12'hD40;
  localparam logic [11:0] C_SNOW = 12'hFFF;
  localparam logic [11:0] C_RAIN = 12'h8AF;

  // c*3>>2 with two guard bits so the product cannot overflow.
  function automatic logic [CW_MAX-1:0] tint34(input logic [CW_MAX-1:0] c);
    logic [CW_MAX+1:0] t;
    t = {2'b00, c} + {1'b0, c, 1'b0};
    return t[CW_MAX+1:2];
  endfunction

  // Left-align a 4-bit palette nibble in a CW_MAX-wide channel.
  function automatic logic [CW_MAX-1:0] pal_chan(input logic [3:0] n);
    return {n, (CW_MAX-4)'(0)};
  endfunction

endpackage

// File: rtl/cam_particle_filter_if.sv
// Pixel-stream bus: camera timing/pixel in, composited pixel and slot count out.
interface cam_particle_filter_if #(
  parameter int unsigned COLOR_W = 4,
  parameter int unsigned CNT_W   = 4
);
  import cam_fx_pkg::*;

  logic               v_sync;
  logic               DE;
  logic [COORD_W-1:0] x;
  logic [COORD_W-1:0] y;
  logic [COLOR_W-1:0] cam_r;
  logic [COLOR_W-1:0] cam_g;
  logic [COLOR_W-1:0] cam_b;
  logic [1:0]         mode;
  logic               enable;
  logic [COLOR_W-1:0] out_r;
  logic [COLOR_W-1:0] out_g;
  logic [COLOR_W-1:0] out_b;
  logic               out_de;
  logic [CNT_W-1:0]   active_cnt;

  modport master (
    output v_sync, DE, x, y, cam_r, cam_g, cam_b, mode, enable,
    input  out_r, out_g, out_b, out_de, active_cnt
  );

  modport slave (
    input  v_sync, DE, x, y, cam_r, cam_g, cam_b, mode, enable,
    output out_r, out_g, out_b, out_de, active_cnt
  );

endinterface

// File: rtl/cam_fx_lfsr.sv
// 16-bit Galois LFSR (taps 16,14,13,11) advancing every cycle from a non-zero seed.
module cam_fx_lfsr
  import cam_fx_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              reset,
  output logic [LFSR_W-1:0] lfsr_o
);

  logic [LFSR_W-1:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = {1'b0, lfsr_q[LFSR_W-1:1]} ^ (lfsr_q[0] ? LFSR_TAPS : '0);
  end

  always_ff @(posedge clk) begin
    if (reset) lfsr_q <= SEED;
    else       lfsr_q <= lfsr_d;
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/cam_particle_filter.sv
// Camera particle overlay: per-frame slot update FSM, priority hit test and a
// 2-stage render pipeline compositing particles over a mode-tinted background.
module cam_particle_filter
  import cam_fx_pkg::*;
#(
  parameter int unsigned N_PART       = 8,
  parameter int unsigned COLOR_W      = 4,
  parameter int unsigned H_ACT        = 640,
  parameter int unsigned V_ACT        = 480,
  parameter int unsigned SIZE_LOG2    = 3,
  parameter int unsigned SPAWN_THRESH = 6,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic clk,
  input  logic reset,
  cam_particle_filter_if.slave bus
);

  localparam int unsigned IDX_W     = (N_PART > 1) ? $clog2(N_PART) : 1;
  localparam int unsigned CNT_W     = $clog2(N_PART + 1);
  localparam int unsigned PSIZE     = 1 << SIZE_LOG2;
  localparam int unsigned RAIN_H    = PSIZE * 2;
  localparam int unsigned SPAWN_LIM = H_ACT - PSIZE;

  particle_t         slot_q [N_PART];
  particle_t         slot_d [N_PART];
  upd_state_e        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  fx_mode_e          mode_q, mode_d;
  logic              vs_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [LFSR_W-1:0] lfsr;
  logic              vs_rise;

  cam_fx_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk    (clk),
    .reset  (reset),
    .lfsr_o (lfsr)
  );

  assign vs_rise = bus.v_sync & ~vs_q;

  // Per-frame motion of the slot currently addressed by the update sweep.
  particle_t   cur_slot, upd_slot;
  logic [10:0] upd_py;
  always_comb begin
    cur_slot        = slot_q[idx_q];
    upd_slot        = cur_slot;
    upd_py          = 11'(cur_slot.py) + 11'(cur_slot.vy) + 11'd1;
    upd_slot.py     = upd_py[9:0];
    upd_slot.active = (upd_py < 11'(V_ACT));
    case (cur_slot.dr)
      DR_POS:  upd_slot.px = (cur_slot.px == 10'(H_ACT - 1)) ? '0 : cur_slot.px + 10'd1;
      DR_NEG:  upd_slot.px = (cur_slot.px == '0) ? 10'(H_ACT - 1) : cur_slot.px - 10'd1;
      default: upd_slot.px = cur_slot.px;
    endcase
  end

  // Spawn candidate: lowest free slot, attributes drawn from the LFSR.
  logic             spawn_go;
  logic             free_found;
  logic [IDX_W-1:0] free_idx;
  particle_t        new_slot;
  always_comb begin
    spawn_go   = ({1'b0, lfsr[3:0]} < 5'(SPAWN_THRESH));
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = int'(N_PART) - 1; i >= 0; i--) begin
      if (!slot_q[i].active) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
    new_slot.active = 1'b1;
    new_slot.py     = '0;
    new_slot.px     = (lfsr[9:0] < 10'(SPAWN_LIM)) ? lfsr[9:0] : lfsr[9:0] - 10'd512;
    new_slot.vy     = lfsr[11:10];
    case (lfsr[13:12])
      2'd1:    new_slot.dr = DR_POS;
      2'd2:    new_slot.dr = DR_NEG;
      default: new_slot.dr = DR_ZERO;
    endcase
    new_slot.pal = lfsr[15:14];
  end

  // Frame sequencer: IDLE -> UPDATE (one slot per cycle) -> SPAWN -> IDLE.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mode_d  = mode_q;
    slot_d  = slot_q;
    case (state_q)
      ST_IDLE: begin
        if (vs_rise) begin
          mode_d  = fx_mode_e'(bus.mode);
          idx_d   = '0;
          state_d = ST_UPDATE;
        end
      end
      ST_UPDATE: begin
        if (bus.enable && cur_slot.active) slot_d[idx_q] = upd_slot;
        if (idx_q == IDX_W'(N_PART - 1)) state_d = ST_SPAWN;
        else                             idx_d   = idx_q + IDX_W'(1);
      end
      ST_SPAWN: begin
        if (bus.enable && spawn_go && free_found) slot_d[free_idx] = new_slot;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < int'(N_PART); i++) cnt_d = cnt_d + CNT_W'(slot_q[i].active);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      mode_q  <= MAPLE;
      vs_q    <= 1'b0;
      cnt_q   <= '0;
      for (int i = 0; i < int'(N_PART); i++) slot_q[i] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mode_q  <= mode_d;
      vs_q    <= bus.v_sync;
      cnt_q   <= cnt_d;
      slot_q  <= slot_d;
    end
  end

  function automatic logic in_span(input logic [9:0] pos, input logic [9:0] org,
                                   input int unsigned len);
    return (11'(pos) >= 11'(org)) && (11'(pos) < 11'(org) + 11'(len));
  endfunction

  // Hit test; scanning downward lets the lowest active index win.
  logic       hit_c;
  logic [1:0] hit_pal_c;
  always_comb begin
    hit_c     = 1'b0;
    hit_pal_c = '0;
    for (int i = int'(N_PART) - 1; i >= 0; i--) begin
      if (slot_q[i].active &&
          ((mode_q == RAIN) ? ((bus.x == slot_q[i].px) && in_span(bus.y, slot_q[i].py, RAIN_H))
                            : (in_span(bus.x, slot_q[i].px, PSIZE) &&
                               in_span(bus.y, slot_q[i].py, PSIZE)))) begin
        hit_c     = 1'b1;
        hit_pal_c = slot_q[i].pal;
      end
    end
  end

  logic               s1_de_q, s1_hit_q;
  logic [1:0]         s1_pal_q;
  fx_mode_e           s1_mode_q;
  logic [COLOR_W-1:0] s1_r_q, s1_g_q, s1_b_q;
  logic [COLOR_W-1:0] out_r_q, out_g_q, out_b_q, out_r_d, out_g_d, out_b_d;
  logic               out_de_q;
  logic [11:0]        pcol;
  logic [CW_MAX-1:0]  tr, tg, tb, pr, pg, pb;
  logic               unused_c;

  // Stage-2 colour select: bypass, particle or tinted background.
  always_comb begin
    case (s1_mode_q)
      MAPLE:   pcol = (s1_pal_q == 2'd0) ? C_YEL : (s1_pal_q == 2'd1) ? C_ORG : C_RED;
      SNOW:    pcol = C_SNOW;
      default: pcol = C_RAIN;
    endcase
    tr      = tint34(CW_MAX'(s1_r_q));
    tg      = tint34(CW_MAX'(s1_g_q));
    tb      = tint34(CW_MAX'(s1_b_q));
    pr      = pal_chan(pcol[11:8]);
    pg      = pal_chan(pcol[7:4]);
    pb      = pal_chan(pcol[3:0]);
    out_r_d = '0;
    out_g_d = '0;
    out_b_d = '0;
    if (s1_de_q) begin
      if (s1_mode_q == BYPASS) begin
        out_r_d = s1_r_q;
        out_g_d = s1_g_q;
        out_b_d = s1_b_q;
      end else if (s1_hit_q) begin
        out_r_d = pr[CW_MAX-1 -: COLOR_W];
        out_g_d = pg[CW_MAX-1 -: COLOR_W];
        out_b_d = pb[CW_MAX-1 -: COLOR_W];
      end else begin
        out_r_d = (s1_mode_q == MAPLE) ? s1_r_q : tr[COLOR_W-1:0];
        out_g_d = (s1_mode_q == SNOW)  ? s1_g_q : tg[COLOR_W-1:0];
        out_b_d = (s1_mode_q == SNOW)  ? s1_b_q : tb[COLOR_W-1:0];
      end
    end
  end

  assign unused_c = ^{tr, tg, tb, pr, pg, pb};

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_de_q   <= 1'b0;
      s1_hit_q  <= 1'b0;
      s1_pal_q  <= '0;
      s1_mode_q <= MAPLE;
      s1_r_q    <= '0;
      s1_g_q    <= '0;
      s1_b_q    <= '0;
      out_r_q   <= '0;
      out_g_q   <= '0;
      out_b_q   <= '0;
      out_de_q  <= 1'b0;
    end else begin
      s1_de_q   <= bus.DE;
      s1_hit_q  <= hit_c;
      s1_pal_q  <= hit_pal_c;
      s1_mode_q <= mode_q;
      s1_r_q    <= bus.cam_r;
      s1_g_q    <= bus.cam_g;
      s1_b_q    <= bus.cam_b;
      out_r_q   <= out_r_d;
      out_g_q   <= out_g_d;
      out_b_q   <= out_b_d;
      out_de_q  <= s1_de_q;
    end
  end

  assign bus.out_r      = out_r_q;
  assign bus.out_g      = out_g_q;
  assign bus.out_b      = out_b_q;
  assign bus.out_de     = out_de_q;
  assign bus.active_cnt = cnt_q;

endmodule

// File: tb/tb_cam_particle_filter.sv
// Bench for cam_particle_filter: directed literal checks, then randomized
// frames compared every cycle against a behavioural slot/pixel model.
module tb_cam_particle_filter;

  localparam int NP   = 8;
  localparam int CW   = 4;
  localparam int HA   = 640;
  localparam int VA   = 480;
  localparam int SL   = 3;
  localparam int TH   = 16;
  localparam int CNTW = 4;
  localparam int PS   = 1 << SL;

  logic clk = 1'b0;
  logic rst;

  cam_particle_filter_if #(.COLOR_W(CW), .CNT_W(CNTW)) bus ();

  cam_particle_filter #(
    .N_PART(NP), .COLOR_W(CW), .H_ACT(HA), .V_ACT(VA),
    .SIZE_LOG2(SL), .SPAWN_THRESH(TH), .LFSR_SEED(16'hACE1)
  ) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model state.
  int m_act [NP], m_px [NP], m_py [NP], m_vy [NP], m_dr [NP], m_pal [NP];
  int m_lfsr, m_phase, m_idx, m_modeq, m_vsq, m_cnt;
  int s1_de, s1_hit, s1_pal, s1_r, s1_g, s1_b, s1_mode;
  int e_de, e_r, e_g, e_b;
  bit model_valid = 1'b0;
  int dut_max_cnt = 0;

  function automatic int lfsr_next(input int v);
    return (v >> 1) ^ (((v & 1) != 0) ? 32'hB400 : 0);
  endfunction

  function automatic int pcolor(input int mode, input int pal);
    if (mode == 1) return 'hFFF;
    if (mode == 2) return 'h8AF;
    if (pal == 0)  return 'hFE0;
    if (pal == 1)  return 'hFA0;
    return 'hD40;
  endfunction

  function automatic int t34(input int c);
    return (c * 3) / 4;
  endfunction

  always @(posedge clk) begin
    int h, pc, l, fr, xi, yi, sum;
    if (rst) begin
      for (int i = 0; i < NP; i++) begin
        m_act[i] = 0; m_px[i] = 0; m_py[i] = 0; m_vy[i] = 0; m_dr[i] = 0; m_pal[i] = 0;
      end
      m_lfsr = 'hACE1; m_phase = 0; m_idx = 0; m_modeq = 0; m_vsq = 0; m_cnt = 0;
      s1_de = 0; s1_hit = 0; s1_pal = 0; s1_r = 0; s1_g = 0; s1_b = 0; s1_mode = 0;
      e_de = 0; e_r = 0; e_g = 0; e_b = 0;
      model_valid = 1'b1;
    end else begin
      // Output stage from what was captured one cycle earlier.
      e_de = s1_de; e_r = 0; e_g = 0; e_b = 0;
      if (s1_de != 0) begin
        if (s1_mode == 3) begin
          e_r = s1_r; e_g = s1_g; e_b = s1_b;
        end else if (s1_hit != 0) begin
          pc = pcolor(s1_mode, s1_pal);
          e_r = (pc >> 8) & 15; e_g = (pc >> 4) & 15; e_b = pc & 15;
        end else begin
          e_r = (s1_mode == 0) ? s1_r : t34(s1_r);
          e_g = (s1_mode == 1) ? s1_g : t34(s1_g);
          e_b = (s1_mode == 1) ? s1_b : t34(s1_b);
        end
      end
      // Capture stage: lowest-index particle covering the current pixel.
      xi = int'(bus.x); yi = int'(bus.y); h = -1;
      for (int i = 0; i < NP; i++) begin
        if (h < 0 && m_act[i] != 0) begin
          if (m_modeq == 2) begin
            if (xi == m_px[i] && yi >= m_py[i] && yi < m_py[i] + 2 * PS) h = i;
          end else if (xi >= m_px[i] && xi < m_px[i] + PS && yi >= m_py[i] && yi < m_py[i] + PS) begin
            h = i;
          end
        end
      end
      s1_de = int'(bus.DE); s1_hit = (h >= 0); s1_pal = (h >= 0) ? m_pal[h] : 0;
      s1_r = int'(bus.cam_r); s1_g = int'(bus.cam_g); s1_b = int'(bus.cam_b); s1_mode = m_modeq;
      sum = 0;
      for (int i = 0; i < NP; i++) sum += m_act[i];
      m_cnt = sum;
      // Frame sequencing.
      if (m_phase == 0) begin
        if (bus.v_sync && m_vsq == 0) begin
          m_modeq = int'(bus.mode); m_phase = 1; m_idx = 0;
        end
      end else if (m_phase == 1) begin
        if (bus.enable && m_act[m_idx] != 0) begin
          m_py[m_idx] = m_py[m_idx] + m_vy[m_idx] + 1;
          m_px[m_idx] = (m_px[m_idx] + m_dr[m_idx] + HA) % HA;
          if (m_py[m_idx] >= VA) m_act[m_idx] = 0;
        end
        m_idx++;
        if (m_idx == NP) m_phase = 2;
      end else begin
        if (bus.enable && (m_lfsr & 15) < TH) begin
          fr = -1;
          for (int i = NP - 1; i >= 0; i--) if (m_act[i] == 0) fr = i;
          if (fr >= 0) begin
            l = m_lfsr & 1023;
            m_act[fr] = 1; m_py[fr] = 0;
            m_px[fr]  = (l < HA - PS) ? l : l - 512;
            m_vy[fr]  = (m_lfsr >> 10) & 3;
            case ((m_lfsr >> 12) & 3)
              1: m_dr[fr] = 1;
              2: m_dr[fr] = -1;
              default: m_dr[fr] = 0;
            endcase
            m_pal[fr] = (m_lfsr >> 14) & 3;
          end
        end
        m_phase = 0;
      end
      m_vsq  = int'(bus.v_sync);
      m_lfsr = lfsr_next(m_lfsr);
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (model_valid) begin
      check("out_de", int'(bus.out_de), e_de);
      check("out_r", int'(bus.out_r), e_r);
      check("out_g", int'(bus.out_g), e_g);
      check("out_b", int'(bus.out_b), e_b);
      check("active_cnt", int'(bus.active_cnt), m_cnt);
      if (int'(bus.active_cnt) > dut_max_cnt) dut_max_cnt = int'(bus.active_cnt);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_pix(input int de, input int x, input int y, input int r, input int g, input int b);
    bus.DE = de[0]; bus.x = 10'(x); bus.y = 10'(y);
    bus.cam_r = 4'(r); bus.cam_g = 4'(g); bus.cam_b = 4'(b);
  endtask

  task automatic rand_pix();
    int s;
    s = int'($urandom_range(0, NP - 1));
    if ($urandom_range(0, 1) == 0 && m_act[s] != 0)
      set_pix(int'($urandom_range(0, 4) != 0), m_px[s] + int'($urandom_range(0, 10)) - 1,
              m_py[s] + int'($urandom_range(0, 18)) - 1, int'($urandom_range(0, 15)),
              int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
    else
      set_pix(int'($urandom_range(0, 4) != 0), int'($urandom_range(0, HA - 1)),
              int'($urandom_range(0, VA - 1)), int'($urandom_range(0, 15)),
              int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
  endtask

  initial begin
    int px0, pal0, pc;
    rst = 1'b1; bus.v_sync = 1'b0; bus.mode = 2'd0; bus.enable = 1'b0;
    set_pix(0, 0, 0, 0, 0, 0);
    tick(3);
    check("lfsr_model_step", lfsr_next('hACE1), 'hE270);
    check("rst_out_de", int'(bus.out_de), 0);
    check("rst_active_cnt", int'(bus.active_cnt), 0);
    check("rst_out_r", int'(bus.out_r), 0);
    rst = 1'b0;

    // Maple tint on a white pixel with no particles.
    set_pix(1, 0, 0, 15, 15, 15);
    tick(2);
    check("tint_out_de", int'(bus.out_de), 1);
    check("tint_r", int'(bus.out_r), 15);
    check("tint_g", int'(bus.out_g), 11);
    check("tint_b", int'(bus.out_b), 11);

    // Bypass after a frame edge, particles frozen.
    bus.mode = 2'd3; bus.v_sync = 1'b1; tick(1); bus.v_sync = 1'b0;
    tick(NP + 3);
    check("bypass_r", int'(bus.out_r), 15);
    check("bypass_g", int'(bus.out_g), 15);
    check("bypass_b", int'(bus.out_b), 15);
    check("bypass_cnt", int'(bus.active_cnt), 0);
    set_pix(0, 0, 0, 15, 15, 15);
    tick(2);
    check("de_low_out_de", int'(bus.out_de), 0);
    check("de_low_r", int'(bus.out_r), 0);
    check("de_low_g", int'(bus.out_g), 0);

    // First spawn lands N_PART+3 cycles after the edge.
    bus.mode = 2'd0; bus.enable = 1'b1; bus.v_sync = 1'b1; tick(1); bus.v_sync = 1'b0;
    tick(NP + 1);
    check("cnt_before_spawn", int'(bus.active_cnt), 0);
    tick(1);
    check("cnt_after_spawn", int'(bus.active_cnt), 1);
    px0 = m_px[0]; pal0 = m_pal[0]; pc = pcolor(0, pal0);
    set_pix(1, px0, 0, 0, 0, 0); tick(2);
    check("spawn_pix_tl_r", int'(bus.out_r), (pc >> 8) & 15);
    check("spawn_pix_tl_g", int'(bus.out_g), (pc >> 4) & 15);
    set_pix(1, px0 + PS - 1, PS - 1, 0, 0, 0); tick(2);
    check("spawn_pix_br_b", int'(bus.out_b), pc & 15);
    check("spawn_pix_br_r", int'(bus.out_r), (pc >> 8) & 15);
    set_pix(1, px0 + PS, 0, 0, 0, 0); tick(2);
    check("spawn_pix_outside_r", int'(bus.out_r), 0);

    // Reset while the sweep is on slot 3.
    set_pix(1, 5, 5, 9, 9, 9);
    bus.v_sync = 1'b1; tick(1); bus.v_sync = 1'b0;
    tick(3);
    rst = 1'b1; tick(1);
    check("rstmid_cnt", int'(bus.active_cnt), 0);
    check("rstmid_out_de", int'(bus.out_de), 0);
    check("rstmid_out_r", int'(bus.out_r), 0);
    rst = 1'b0;

    // Randomized frames: mode/enable changes, extra v_sync pulses during update.
    for (int f = 0; f < 700; f++) begin
      if ($urandom_range(0, 7) == 0) bus.mode = 2'($urandom_range(0, 3));
      bus.enable = ($urandom_range(0, 9) != 0);
      bus.v_sync = 1'b1;
      rand_pix();
      tick(int'($urandom_range(1, 3)));
      for (int c = 0; c < NP + 2; c++) begin
        bus.v_sync = (c == 3 && $urandom_range(0, 3) == 0);
        rand_pix();
        tick(1);
      end
      bus.v_sync = 1'b0;
      for (int c = 0; c < 12; c++) begin
        if ($urandom_range(0, 29) == 0) bus.mode = 2'($urandom_range(0, 3));
        rand_pix();
        tick(1);
      end
      if (f == 350) begin
        rst = 1'b1; tick(1); rst = 1'b0;
      end
    end
    tick(3);
    check("cnt_saturated", dut_max_cnt, NP);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
